anc_out_ctrl: RTL

Output sequencing controller between the ANC filter outputs (yn1/yn2) and the WM8978 DAC path. Per channel, it applies a soft-mute gain ramp, gated by the enable key, the calibration-busy flag and the speaker-amplifier fault inputs. It drives the amplifier mute pins. A single 16x10 multiplier is time-shared across both channels, scheduled off the per-frame receive strobe.

---
 rtl/anc_out_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/anc_out_ctrl.sv
// ANC output sequencing: per-channel soft-mute gain ramp with fault hold-off,
// amp mute control and one gain multiplier shared by both channels per frame.

module anc_out_ch #(
   parameter int STEP        = 1,
   parameter int HOLD_FRAMES = 4800,
   parameter int HW          = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       go,
   input  logic       fs,
   output logic [2:0] st,
   output logic [8:0] gain,
   output logic       mute
);
   // state     | meaning
   // ----------+------------------------------------------------------
   // MUTE      | gain 0, amp muted, waiting for go on a frame
   // RAMP_UP   | gain rising by STEP per frame toward full scale
   // ACTIVE    | gain at full scale (256), exact pass-through
   // RAMP_DOWN | gain falling by STEP per frame toward 0
   // FAULT     | amp fault seen; muted until hold counter expires
   typedef enum logic [2:0] {
      S_MUTE      = 3'd0,
      S_RAMP_UP   = 3'd1,
      S_ACTIVE    = 3'd2,
      S_RAMP_DOWN = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   localparam logic [8:0]    GAIN_FS = 9'd256;
   localparam logic [8:0]    STEP_G  = 9'(STEP);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_FRAMES);

   state_t        state, state_nx;
   logic [8:0]    gain_nx, gain_up, gain_dn;
   logic [9:0]    up_sum;
   logic [HW-1:0] hold, hold_nx;

   assign up_sum  = {1'b0, gain} + {1'b0, STEP_G};
   assign gain_up = (up_sum >= 10'd256) ? GAIN_FS : up_sum[8:0];
   assign gain_dn = (gain > STEP_G) ? (gain - STEP_G) : 9'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_MUTE;
         gain  <= 9'd0;
         hold  <= '0;
      end else begin
         state <= state_nx;
         gain  <= gain_nx;
         hold  <= hold_nx;
      end
   end

   always_comb begin
      state_nx = state;
      gain_nx  = gain;
      hold_nx  = hold;
      if (fs) begin
         state_nx = S_FAULT;
         gain_nx  = 9'd0;
         hold_nx  = HOLD_LD;
      end else if (tick) begin
         case (state)
            S_MUTE: begin
               if (go) begin
                  state_nx = S_RAMP_UP;
                  gain_nx  = gain_up;
               end
            end
            S_RAMP_UP: begin
               if (!go) begin
                  state_nx = S_RAMP_DOWN;
                  gain_nx  = gain_dn;
               end else begin
                  gain_nx = gain_up;
                  if (gain_up == GAIN_FS) state_nx = S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (!go) begin
                  state_nx = S_RAMP_DOWN;
                  gain_nx  = gain_dn;
               end
            end
            S_RAMP_DOWN: begin
               if (go) begin
                  state_nx = S_RAMP_UP;
                  gain_nx  = gain_up;
               end else begin
                  gain_nx = gain_dn;
                  if (gain_dn == 9'd0) state_nx = S_MUTE;
               end
            end
            S_FAULT: begin
               // hold-off timer: terminal count releases to MUTE
               if (hold == '0) state_nx = S_MUTE;
               else            hold_nx  = hold - 1'b1;
            end
            default: begin
               state_nx = S_MUTE;
               gain_nx  = 9'd0;
            end
         endcase
      end
   end

   assign st   = state;
   assign mute = (state == S_MUTE) || (state == S_FAULT);

endmodule

module anc_out_ctrl #(
   parameter int DW          = 16,
   parameter int STEP        = 1,
   parameter int HOLD_FRAMES = 4800,
   parameter int HW          = 13
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_stb,
   input  logic                 enable_i,
   input  logic                 cal_busy_i,
   input  logic                 fault1_i,
   input  logic                 fault2_i,
   input  logic signed [DW-1:0] yn1_i,
   input  logic signed [DW-1:0] yn2_i,
   output logic signed [DW-1:0] yn1_o,
   output logic signed [DW-1:0] yn2_o,
   output logic                 out_vld,
   output logic                 mute1_o,
   output logic                 mute2_o,
   output logic [2:0]           st1_o,
   output logic [2:0]           st2_o
);
   logic [1:0]           f1_sync, f2_sync;
   logic [1:0]           ph;
   logic                 idle, tick, go;
   logic signed [DW-1:0] x1, x2, r1, r2, mul_x, mul_r;
   logic [8:0]           g1, g2, mul_g;
   logic signed [9:0]    mul_gs;
   logic signed [DW+9:0] prod;
   logic                 unused_prod;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         f1_sync <= 2'b00;
         f2_sync <= 2'b00;
      end else begin
         f1_sync <= {f1_sync[0], fault1_i};
         f2_sync <= {f2_sync[0], fault2_i};
      end
   end

   // ph: 0 idle, 1 ch1 multiply, 2 ch2 multiply, 3 output load (can accept)
   assign idle = (ph == 2'd0) || (ph == 2'd3);
   assign tick = frame_stb & idle;
   assign go   = enable_i & ~cal_busy_i;

   anc_out_ch #(.STEP(STEP), .HOLD_FRAMES(HOLD_FRAMES), .HW(HW)) u_ch1 (
      .clk(clk), .rst_n(rst_n), .tick(tick), .go(go), .fs(f1_sync[1]),
      .st(st1_o), .gain(g1), .mute(mute1_o)
   );

   anc_out_ch #(.STEP(STEP), .HOLD_FRAMES(HOLD_FRAMES), .HW(HW)) u_ch2 (
      .clk(clk), .rst_n(rst_n), .tick(tick), .go(go), .fs(f2_sync[1]),
      .st(st2_o), .gain(g2), .mute(mute2_o)
   );

   assign mul_x  = (ph == 2'd1) ? x1 : x2;
   assign mul_g  = (ph == 2'd1) ? g1 : g2;
   assign mul_gs = {1'b0, mul_g};
   assign prod   = mul_x * mul_gs;
   // gain <= 256 keeps the >>>8 result inside DW bits
   assign mul_r       = prod[DW+7:8];
   assign unused_prod = ^{prod[DW+9:DW+8], prod[7:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph      <= 2'd0;
         x1      <= '0;
         x2      <= '0;
         r1      <= '0;
         r2      <= '0;
         yn1_o   <= '0;
         yn2_o   <= '0;
         out_vld <= 1'b0;
      end else begin
         out_vld <= 1'b0;
         if (tick) begin
            x1 <= yn1_i;
            x2 <= yn2_i;
         end
         case (ph)
            2'd1: r1 <= mul_r;
            2'd2: r2 <= mul_r;
            2'd3: begin
               yn1_o   <= mute1_o ? '0 : r1;
               yn2_o   <= mute2_o ? '0 : r2;
               out_vld <= 1'b1;
            end
            default: ;
         endcase
         if (tick)            ph <= 2'd1;
         else if (ph == 2'd3) ph <= 2'd0;
         else if (ph != 2'd0) ph <= ph + 2'd1;
      end
   end

endmodule
